// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared types, widths and colour-bar table for cam_capture_scaler
package cam_pkg;

  typedef enum logic [1:0] {
    CAM_MODE_RGB565 = 2'd0,
    CAM_MODE_RGB444 = 2'd1,
    CAM_MODE_Y      = 2'd2
  } cam_mode_e;

  typedef logic [1:0] cam_state_t;
  localparam cam_state_t ST_IDLE       = 2'd0;
  localparam cam_state_t ST_WAIT_VSYNC = 2'd1;
  localparam cam_state_t ST_ACTIVE     = 2'd2;

  localparam int RAW_COL_W  = 11;
  localparam int RAW_LINE_W = 10;
  localparam int PIX_X_W    = 10;
  localparam int PIX_Y_W    = 9;
  localparam int PHASE_W    = 3;
  localparam int RGB_W      = 12;

  // white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [RGB_W-1:0] COLOUR_BARS [8] = '{
    12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000
  };

  function automatic logic [RGB_W-1:0] cam_format(cam_mode_e mode, logic [7:0] b0, logic [7:0] b1);
    case (mode)
      CAM_MODE_RGB444: return {b0[3:0], b1[7:4], b1[3:0]};
      CAM_MODE_Y:      return {b0[7:4], b0[7:4], b0[7:4]};
      default:         return {b0[7:4], b0[2:0], b1[7], b1[4:1]};
    endcase
  endfunction

endpackage

// File: rtl/cam_pix_fifo.sv
// rtl/cam_pix_fifo.sv - synchronous FIFO carrying pixel+coordinate words to the frame buffer
module cam_pix_fifo #(
  parameter int WIDTH = 31,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             rd_fire, wr_fire;

  assign o_empty   = (wr_ptr_q == rd_ptr_q);
  assign o_full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rd_fire   = i_rd_en && !o_empty;
  // a full FIFO still accepts a write when the head leaves in the same cycle
  assign wr_fire   = i_wr_en && (!o_full || rd_fire);
  assign o_rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (wr_fire) begin
        mem_q[wr_ptr_q[AW-1:0]] <= i_wr_data;
        wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      end
      if (rd_fire) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/cam_capture_scaler.sv
// rtl/cam_capture_scaler.sv - OV7670 oversampling capture, pixel assembly, XY decimation, output FIFO
// Optional colour-bar test pattern input enabled by CAM_CAPTURE_TESTPAT_EN.
module cam_capture_scaler
  import cam_pkg::*;
#(
  parameter int CAM_WIDTH  = 640,
  parameter int CAM_HEIGHT = 480,
  parameter int DECIM_X    = 2,
  parameter int DECIM_Y    = 2,
  parameter int PIXEL_BITS = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_enable,
  input  logic [1:0]            i_mode,
`ifdef CAM_CAPTURE_TESTPAT_EN
  input  logic                  i_testpat,
`endif
  input  logic                  i_pclk,
  input  logic                  i_vsync,
  input  logic                  i_href,
  input  logic [7:0]            i_cam_data,
  output logic                  o_pix_valid,
  input  logic                  i_pix_ready,
  output logic [PIXEL_BITS-1:0] o_pix_data,
  output logic [PIX_X_W-1:0]    o_pix_x,
  output logic [PIX_Y_W-1:0]    o_pix_y,
  output logic                  o_frame_start,
  output logic                  o_frame_done,
  output logic                  o_short_frame,
  output logic                  o_overflow,
  output logic [15:0]           o_frame_count
);
  localparam int FIFO_W = PIXEL_BITS + PIX_X_W + PIX_Y_W;
  localparam logic [RAW_COL_W-1:0]  WIDTH_L  = RAW_COL_W'(CAM_WIDTH);
  localparam logic [RAW_LINE_W-1:0] HEIGHT_L = RAW_LINE_W'(CAM_HEIGHT);
  localparam logic [PHASE_W-1:0]    XPH_LAST = PHASE_W'(DECIM_X - 1);
  localparam logic [PHASE_W-1:0]    YPH_LAST = PHASE_W'(DECIM_Y - 1);

  // stages [0],[1] synchronise, [2] is the previous value for edge detection
  logic [2:0] pclk_q, vsync_q, href_q;
  logic [7:0] data_s1_q, data_s2_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pclk_q    <= '0;
      vsync_q   <= '0;
      href_q    <= '0;
      data_s1_q <= '0;
      data_s2_q <= '0;
    end else begin
      pclk_q    <= {pclk_q[1:0], i_pclk};
      vsync_q   <= {vsync_q[1:0], i_vsync};
      href_q    <= {href_q[1:0], i_href};
      data_s1_q <= i_cam_data;
      data_s2_q <= data_s1_q;
    end
  end

  logic pclk_rise, href_rise, href_fall, vs_rise, vs_fall;
  assign pclk_rise = pclk_q[1] && !pclk_q[2];
  assign href_rise = href_q[1] && !href_q[2];
  assign href_fall = !href_q[1] && href_q[2];
  assign vs_rise   = vsync_q[1] && !vsync_q[2];
  assign vs_fall   = !vsync_q[1] && vsync_q[2];

  cam_state_t state_q, state_d;
  logic       start_evt, done_evt;
  assign start_evt = i_enable && (state_q == ST_WAIT_VSYNC) && vs_fall;
  assign done_evt  = i_enable && (state_q == ST_ACTIVE) && vs_rise;

  always_comb begin
    state_d = state_q;
    if (!i_enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:       state_d = ST_WAIT_VSYNC;
        ST_WAIT_VSYNC: if (vs_fall) state_d = ST_ACTIVE;
        ST_ACTIVE:     if (vs_rise) state_d = ST_WAIT_VSYNC;
        default:       state_d = ST_IDLE;
      endcase
    end
  end

  logic       byte_stb, phase_eff, pix_stb, phase_q;
  logic [7:0] b0_q;
  assign byte_stb  = (state_q == ST_ACTIVE) && pclk_rise && href_q[1];
  assign phase_eff = href_rise ? 1'b0 : phase_q;
  assign pix_stb   = byte_stb && phase_eff;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      phase_q <= 1'b0;
      b0_q    <= '0;
    end else if (byte_stb) begin
      phase_q <= !phase_eff;
      if (!phase_eff) b0_q <= data_s2_q;
    end else if (href_rise) begin
      phase_q <= 1'b0;
    end
  end

  logic [RAW_COL_W-1:0]  col_q;
  logic [RAW_LINE_W-1:0] line_q;
  logic [PHASE_W-1:0]    xph_q, yph_q;
  logic [PIX_X_W-1:0]    dx_q;
  logic [PIX_Y_W-1:0]    dy_q;
  logic                  in_range, keep;
  assign in_range = (col_q < WIDTH_L) && (line_q < HEIGHT_L);
  assign keep     = pix_stb && in_range && (xph_q == '0) && (yph_q == '0);

  // col/line stop counting at the active size, so overlong lines and frames cannot wrap back in
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      col_q  <= '0;
      line_q <= '0;
      xph_q  <= '0;
      yph_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
    end else if (start_evt) begin
      col_q  <= '0;
      line_q <= '0;
      xph_q  <= '0;
      yph_q  <= '0;
      dx_q   <= '0;
      dy_q   <= '0;
    end else if (state_q == ST_ACTIVE) begin
      if (pix_stb && in_range) begin
        col_q <= col_q + RAW_COL_W'(1);
        xph_q <= (xph_q == XPH_LAST) ? '0 : xph_q + PHASE_W'(1);
        if (keep) dx_q <= dx_q + PIX_X_W'(1);
      end else if (href_fall && (col_q != '0)) begin
        col_q <= '0;
        xph_q <= '0;
        dx_q  <= '0;
        if (line_q < HEIGHT_L) begin
          line_q <= line_q + RAW_LINE_W'(1);
          yph_q  <= (yph_q == YPH_LAST) ? '0 : yph_q + PHASE_W'(1);
          if (yph_q == '0) dy_q <= dy_q + PIX_Y_W'(1);
        end
      end
    end
  end

  cam_mode_e        mode_q;
  logic [RGB_W-1:0] rgb;

`ifdef CAM_CAPTURE_TESTPAT_EN
  logic testpat_q;
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn)        testpat_q <= 1'b0;
    else if (start_evt) testpat_q <= i_testpat;
  end
`endif

  always_comb begin
    rgb = cam_format(mode_q, b0_q, data_s2_q);
`ifdef CAM_CAPTURE_TESTPAT_EN
    if (testpat_q) rgb = COLOUR_BARS[col_q[9:7]];
`endif
  end

  logic              push_q;
  logic [FIFO_W-1:0] push_data_q;
  logic [FIFO_W-1:0] fifo_rd_data;
  logic              fifo_full, fifo_empty, pop, overflow_evt;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= keep;
      if (keep) push_data_q <= {dx_q, dy_q, PIXEL_BITS'(rgb)};
    end
  end

  cam_pix_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rstn    (i_rstn),
    .i_wr_en   (push_q),
    .i_wr_data (push_data_q),
    .i_rd_en   (i_pix_ready),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty)
  );

  assign o_pix_valid  = !fifo_empty;
  assign pop          = o_pix_valid && i_pix_ready;
  assign overflow_evt = push_q && fifo_full && !pop;
  assign {o_pix_x, o_pix_y, o_pix_data} = fifo_rd_data;

  logic        frame_start_q, frame_done_q, short_q, overflow_q;
  logic [15:0] frame_count_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q       <= ST_IDLE;
      mode_q        <= CAM_MODE_RGB565;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      short_q       <= 1'b0;
      overflow_q    <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      frame_start_q <= start_evt;
      frame_done_q  <= done_evt;
      if (start_evt) mode_q <= (i_mode == 2'd3) ? CAM_MODE_RGB565 : cam_mode_e'(i_mode);
      if (done_evt) begin
        frame_count_q <= frame_count_q + 16'd1;
        short_q       <= (line_q < HEIGHT_L);
      end
      if (overflow_evt)   overflow_q <= 1'b1;
      else if (start_evt) overflow_q <= 1'b0;
    end
  end

  assign o_frame_start = frame_start_q;
  assign o_frame_done  = frame_done_q;
  assign o_short_frame = short_q;
  assign o_overflow    = overflow_q;
  assign o_frame_count = frame_count_q;

endmodule

// File: tb/tb_cam_capture_scaler.sv
// tb/tb_cam_capture_scaler.sv - randomized scoreboard bench for cam_capture_scaler (small frame geometry)
module tb_cam_capture_scaler;
  localparam int W  = 16;
  localparam int H  = 8;
  localparam int DX = 2;
  localparam int DY = 2;

  logic        clk;
  logic        i_rstn, i_enable, i_pclk, i_vsync, i_href, i_pix_ready;
  logic [1:0]  i_mode;
  logic [7:0]  i_cam_data;
  logic        o_pix_valid, o_frame_start, o_frame_done, o_short_frame, o_overflow;
  logic [11:0] o_pix_data;
  logic [9:0]  o_pix_x;
  logic [8:0]  o_pix_y;
  logic [15:0] o_frame_count;

  cam_capture_scaler #(
    .CAM_WIDTH (W), .CAM_HEIGHT (H), .DECIM_X (DX), .DECIM_Y (DY),
    .PIXEL_BITS (12), .FIFO_DEPTH (4)
  ) dut (
    .i_clk (clk), .i_rstn (i_rstn), .i_enable (i_enable), .i_mode (i_mode),
    .i_pclk (i_pclk), .i_vsync (i_vsync), .i_href (i_href), .i_cam_data (i_cam_data),
    .o_pix_valid (o_pix_valid), .i_pix_ready (i_pix_ready), .o_pix_data (o_pix_data),
    .o_pix_x (o_pix_x), .o_pix_y (o_pix_y), .o_frame_start (o_frame_start),
    .o_frame_done (o_frame_done), .o_short_frame (o_short_frame),
    .o_overflow (o_overflow), .o_frame_count (o_frame_count)
  );

  typedef struct { int x; int y; int pix; } exp_t;
  exp_t sb[$];

  int n_checks = 0, n_errors = 0;
  int done_cnt = 0, start_cnt = 0, exp_frames = 0;
  bit hold_ready = 0, model_live = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  function automatic int model_pix(int mode, int b0, int b1);
    int r, g, b;
    case (mode)
      1: begin r = b0 % 16; g = b1 / 16; b = b1 % 16; end
      2: begin r = b0 / 16; g = r; b = r; end
      default: begin
        r = (b0 / 8) / 2;
        g = ((b0 % 8) * 8 + b1 / 32) / 4;
        b = (b1 % 32) / 2;
      end
    endcase
    return r * 256 + g * 16 + b;
  endfunction

  initial begin
    i_pix_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      i_pix_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [30:0] held;
    bit          held_v;
    exp_t        e;
    held_v = 0;
    forever begin
      @(negedge clk);
      if (o_frame_done) done_cnt++;
      if (o_frame_start) start_cnt++;
      if (!i_rstn || !o_pix_valid) begin
        held_v = 0;
      end else begin
        if (held_v) check("hold_stable", 64'({o_pix_x, o_pix_y, o_pix_data}), 64'(held));
        if (i_pix_ready) begin
          held_v = 0;
          n_checks++;
          if (sb.size() == 0) begin
            n_errors++;
            $display("FAIL unexpected_pixel: got x=%0d y=%0d data=%03h, required no pixel",
                     o_pix_x, o_pix_y, o_pix_data);
          end else begin
            e = sb.pop_front();
            if ({o_pix_x, o_pix_y, o_pix_data} !== {10'(e.x), 9'(e.y), 12'(e.pix)}) begin
              n_errors++;
              $display("FAIL pixel: got x=%0d y=%0d data=%03h, required x=%0d y=%0d data=%03h",
                       o_pix_x, o_pix_y, o_pix_data, e.x, e.y, e.pix);
            end
          end
        end else begin
          held   = {o_pix_x, o_pix_y, o_pix_data};
          held_v = 1;
        end
      end
    end
  end

  task automatic pclk_byte(input int b, input logic h);
    i_pclk     = 0;
    i_cam_data = 8'(b);
    i_href     = h;
    #40;
    i_pclk = 1;
    #40;
  endtask

  task automatic blank(input int n);
    repeat (n) pclk_byte($urandom_range(0, 255), 1'b0);
  endtask

  task automatic do_reset();
    i_rstn = 0;
    #1;
    check("reset_outputs", 64'({o_pix_valid, o_pix_data, o_pix_x, o_pix_y, o_frame_start,
                                o_frame_done, o_short_frame, o_overflow, o_frame_count}), 64'(0));
    sb.delete();
    model_live = 0;
    exp_frames = 0;
    done_cnt   = 0;
    start_cnt  = 0;
    #29;
    i_rstn = 1;
  endtask

  // pat: 0 random bytes, 1 F8/1F pairs, 2 A5 first byte with random second byte
  task automatic send_frame(input int mode, input int nlines, input int nbytes, input int pat,
                            input int chg_line, input int rst_line, input int cap);
    int b, b0, pushed, m;
    exp_t e;
    model_live = 1;
    pushed = 0;
    b0 = 0;
    m = (mode == 3) ? 0 : mode;
    i_mode = 2'(mode);
    blank(4);
    i_vsync = 0;
    blank(4);
    for (int l = 0; l < nlines; l++) begin
      if (l == chg_line) i_mode = 2'(mode + 1);
      for (int i = 0; i < nbytes; i++) begin
        case (pat)
          1:       b = (i % 2 == 0) ? 8'hF8 : 8'h1F;
          2:       b = (i % 2 == 0) ? 8'hA5 : $urandom_range(0, 255);
          default: b = $urandom_range(0, 255);
        endcase
        pclk_byte(b, 1'b1);
        if (i % 2 == 0) begin
          b0 = b;
        end else if (model_live && l < H && i / 2 < W && (i / 2) % DX == 0 && l % DY == 0
                     && pushed < cap) begin
          e.x = (i / 2) / DX;
          e.y = l / DY;
          e.pix = model_pix(m, b0, b);
          sb.push_back(e);
          pushed++;
        end
        if (l == rst_line && i == nbytes / 2) do_reset();
      end
      blank(4);
    end
    i_vsync = 1;
    blank(6);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || o_pix_valid) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("drain_remaining", 64'(sb.size()), 64'(0));
  endtask

  task automatic frame_checks(input logic exp_short, input logic exp_ovf);
    check("frame_count", 64'(o_frame_count), 64'(exp_frames));
    check("frame_done_pulses", 64'(done_cnt), 64'(exp_frames));
    check("frame_start_pulses", 64'(start_cnt), 64'(exp_frames));
    check("short_frame", 64'(o_short_frame), 64'(exp_short));
    check("overflow", 64'(o_overflow), 64'(exp_ovf));
  endtask

  initial begin
    #2_000_000;
    n_errors++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    i_rstn = 0; i_enable = 0; i_mode = 0; i_pclk = 0;
    i_vsync = 1; i_href = 0; i_cam_data = 0;
    repeat (4) @(posedge clk);
    #1;
    check("reset_outputs", 64'({o_pix_valid, o_pix_data, o_pix_x, o_pix_y, o_frame_start,
                                o_frame_done, o_short_frame, o_overflow, o_frame_count}), 64'(0));
    i_rstn = 1;
    @(posedge clk);
    #1;
    i_enable = 1;
    repeat (4) @(posedge clk);
    #1;
    check("idle_no_valid", 64'(o_pix_valid), 64'(0));

    send_frame(0, H, 2 * W, 1, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    send_frame(2, H, 2 * W, 2, 3, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    for (int f = 0; f < 3; f++) begin
      send_frame($urandom_range(0, 3), H, 2 * W, 0, $urandom_range(1, H - 1), -1, 1000);
      exp_frames++; drain(); frame_checks(0, 0);
    end

    send_frame(1, H - 1, 2 * W, 0, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(1, 0);

    send_frame(3, H + 1, 2 * W, 0, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    send_frame(0, H, 2 * W + 1, 0, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    send_frame(1, H, 2 * W + 8, 0, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    hold_ready = 1;
    send_frame(0, H, 2 * W, 0, -1, -1, 4);
    exp_frames++;
    repeat (20) @(negedge clk);
    check("overflow_set", 64'(o_overflow), 64'(1));
    check("fifo_held_valid", 64'(o_pix_valid), 64'(1));
    check("fifo_held_count", 64'(sb.size()), 64'(4));
    hold_ready = 0;
    drain(); frame_checks(0, 1);

    send_frame(2, H, 2 * W, 0, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    send_frame(0, H, 2 * W, 0, -1, 3, 1000);
    drain(); frame_checks(0, 0);

    send_frame(1, H, 2 * W, 0, -1, -1, 1000);
    exp_frames++; drain(); frame_checks(0, 0);

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
